// File: rtl/reg_ring_pkg.sv
// reg_ring_pkg
// Shared definitions for the register ring initiator.
//   - ring_state_e     : initiator FSM states
//   - RING_*_W         : ring bus field widths
//   - CTRL_*           : bit positions inside the 7-bit ring control word
//   - ring_pack / ring_unpack_addr / ring_unpack_data : 60-bit {addr, data} bus helpers
//   - ring_ctrl / ring_ctrl_src : control word build / source-field extract
package reg_ring_pkg;

  localparam int RING_ADDR_W = 28;
  localparam int RING_DATA_W = 32;
  localparam int RING_CTRL_W = 7;
  localparam int RING_SRC_W  = 2;
  localparam int RING_BUS_W  = RING_ADDR_W + RING_DATA_W;

  localparam int CTRL_RD_WR_L_BIT = 0;
  localparam int CTRL_SRC_LSB     = 1;
  localparam int CTRL_SRC_MSB     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } ring_state_e;

  function automatic logic [RING_BUS_W-1:0] ring_pack(
    input logic [RING_ADDR_W-1:0] addr,
    input logic [RING_DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

  function automatic logic [RING_ADDR_W-1:0] ring_unpack_addr(
    input logic [RING_BUS_W-1:0] bus
  );
    return bus[RING_BUS_W-1 -: RING_ADDR_W];
  endfunction

  function automatic logic [RING_DATA_W-1:0] ring_unpack_data(
    input logic [RING_BUS_W-1:0] bus
  );
    return bus[RING_DATA_W-1:0];
  endfunction

  // Upper control bits are reserved and always launched as zero.
  function automatic logic [RING_CTRL_W-1:0] ring_ctrl(
    input logic                  rd_wr_l,
    input logic [RING_SRC_W-1:0] src
  );
    logic [RING_CTRL_W-1:0] c;
    c = '0;
    c[CTRL_RD_WR_L_BIT]           = rd_wr_l;
    c[CTRL_SRC_MSB:CTRL_SRC_LSB]  = src;
    return c;
  endfunction

  function automatic logic [RING_SRC_W-1:0] ring_ctrl_src(
    input logic [RING_CTRL_W-1:0] ctrl
  );
    return ctrl[CTRL_SRC_MSB:CTRL_SRC_LSB];
  endfunction

endpackage

// File: rtl/reg_ring_timeout_ctr.sv
// reg_ring_timeout_ctr
// Wait-cycle counter for the ring initiator. Clears on 'clear', counts up
// while 'en' is high and parks at TIMEOUT_CYCLES-1, where 'tc' is high.
// Ports:
//   clk   in  clock
//   srst  in  synchronous active-high reset
//   clear in  load zero (wins over en)
//   en    in  count enable
//   tc    out count == TIMEOUT_CYCLES-1
module reg_ring_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  // TIMEOUT_CYCLES-1 always fits in clog2(TIMEOUT_CYCLES) bits for TIMEOUT_CYCLES >= 2.
  localparam int CTR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CTR_W-1:0] TERMINAL = CTR_W'(TIMEOUT_CYCLES - 1);

  logic [CTR_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (en && (count_reg != TERMINAL)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == TERMINAL);

endmodule

// File: rtl/reg_ring_master.sv
// reg_ring_master
// Initiator end of the register ring. Takes one host request at a time,
// launches it into the ring for one cycle, then waits for the return that
// carries this master's source id and hands back read data / ack / timeout.
// Optional statistics counters are built when REG_RING_MASTER_STATS_EN is
// defined; otherwise stat_stale and stat_timeout read as zero.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_ready           host request handshake
//   req_rd_wr_L, req_addr, req_wr_data   request fields (1 = read)
//   resp_valid/resp_ready         host response handshake
//   resp_rd_data, resp_ack, resp_timeout response fields
//   ring_out_*                    registered launch into the first ring node
//   ring_in_*                     return from the last ring node
//   stat_stale, stat_timeout      saturating drop / timeout counters
module reg_ring_master
  import reg_ring_pkg::*;
#(
  parameter logic [RING_SRC_W-1:0]  SRC_ID         = 2'd0,
  parameter int                     TIMEOUT_CYCLES = 256,
  parameter logic [RING_DATA_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rd_wr_L,
  input  logic [RING_ADDR_W-1:0] req_addr,
  input  logic [RING_DATA_W-1:0] req_wr_data,

  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [RING_DATA_W-1:0] resp_rd_data,
  output logic                   resp_ack,
  output logic                   resp_timeout,

  output logic [RING_BUS_W-1:0]  ring_out_wr_data_bus,
  output logic [RING_CTRL_W-1:0] ring_out_ctrl,
  output logic                   ring_out_vld,
  output logic [RING_DATA_W-1:0] ring_out_rd_data_bus,
  output logic                   ring_out_ack,

  input  logic [RING_BUS_W-1:0]  ring_in_wr_data_bus,
  input  logic [RING_CTRL_W-1:0] ring_in_ctrl,
  input  logic                   ring_in_vld,
  input  logic [RING_DATA_W-1:0] ring_in_rd_data_bus,
  input  logic                   ring_in_ack,

  output logic [15:0]            stat_stale,
  output logic [15:0]            stat_timeout
);

  ring_state_e state_reg;

  logic src_match;
  logic wait_match;
  logic wait_timeout;
  logic ctr_tc;

  // The returning address/data and reserved control bits carry nothing this
  // master needs; the request is identified by src alone.
  logic unused_ring_bits;
  assign unused_ring_bits = ^{ring_in_wr_data_bus,
                              ring_in_ctrl[RING_CTRL_W-1:CTRL_SRC_MSB+1],
                              ring_in_ctrl[CTRL_RD_WR_L_BIT]};

  assign src_match    = ring_in_vld && (ring_ctrl_src(ring_in_ctrl) == SRC_ID);
  assign wait_match   = (state_reg == ST_WAIT) && src_match;
  // A match in the terminal cycle takes priority over the timeout.
  assign wait_timeout = (state_reg == ST_WAIT) && !src_match && ctr_tc;

  reg_ring_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (clk),
    .srst (reset),
    .clear(state_reg == ST_ISSUE),
    .en   (state_reg == ST_WAIT),
    .tc   (ctr_tc)
  );

  // The ring_out_* registers double as the latched request; ring_out_vld is
  // set on acceptance so it is high for exactly the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= ST_IDLE;
      req_ready            <= 1'b1;
      resp_valid           <= 1'b0;
      resp_rd_data         <= '0;
      resp_ack             <= 1'b0;
      resp_timeout         <= 1'b0;
      ring_out_wr_data_bus <= '0;
      ring_out_ctrl        <= '0;
      ring_out_vld         <= 1'b0;
      ring_out_rd_data_bus <= '0;
      ring_out_ack         <= 1'b0;
    end else begin
      ring_out_vld <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready            <= 1'b0;
            ring_out_wr_data_bus <= ring_pack(req_addr, req_wr_data);
            ring_out_ctrl        <= ring_ctrl(req_rd_wr_L, SRC_ID);
            ring_out_rd_data_bus <= '0;
            ring_out_ack         <= 1'b0;
            ring_out_vld         <= 1'b1;
            state_reg            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_match) begin
            resp_ack     <= ring_in_ack;
            resp_rd_data <= ring_out_ctrl[CTRL_RD_WR_L_BIT] ? ring_in_rd_data_bus : '0;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            state_reg    <= ST_RESP;
          end else if (wait_timeout) begin
            resp_ack     <= 1'b0;
            resp_rd_data <= TIMEOUT_DATA;
            resp_timeout <= 1'b1;
            resp_valid   <= 1'b1;
            state_reg    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_reg  <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef REG_RING_MASTER_STATS_EN
  // Any return not consumed as the WAIT match is stale: wrong src, or
  // arriving outside WAIT (late after a timeout or after a reset).
  logic stale_event;
  assign stale_event = ring_in_vld && !wait_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stale   <= '0;
      stat_timeout <= '0;
    end else begin
      if (stale_event && (stat_stale != 16'hFFFF)) begin
        stat_stale <= stat_stale + 16'd1;
      end
      if (wait_timeout && (stat_timeout != 16'hFFFF)) begin
        stat_timeout <= stat_timeout + 16'd1;
      end
    end
  end
`else
  assign stat_stale   = 16'h0;
  assign stat_timeout = 16'h0;
`endif

endmodule

// File: tb/tb_reg_ring_master.sv
// tb_reg_ring_master
// Directed bench for reg_ring_master with TIMEOUT_CYCLES = 8. A one-cycle
// loopback node model (open / ack-with-data / pass-through) plus a manual
// injection path drive the ring return. Statistics expectations follow
// REG_RING_MASTER_STATS_EN.
module tb_reg_ring_master;

`ifdef REG_RING_MASTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd_wr_L;
  logic [27:0] req_addr;
  logic [31:0] req_wr_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd_data;
  logic        resp_ack;
  logic        resp_timeout;
  logic [59:0] ring_out_wr_data_bus;
  logic [6:0]  ring_out_ctrl;
  logic        ring_out_vld;
  logic [31:0] ring_out_rd_data_bus;
  logic        ring_out_ack;
  logic [59:0] ring_in_wr_data_bus;
  logic [6:0]  ring_in_ctrl;
  logic        ring_in_vld;
  logic [31:0] ring_in_rd_data_bus;
  logic        ring_in_ack;
  logic [15:0] stat_stale;
  logic [15:0] stat_timeout;

  always #5 clk = ~clk;

  reg_ring_master #(
    .SRC_ID(2'd0),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd_wr_L(req_rd_wr_L),
    .req_addr(req_addr),
    .req_wr_data(req_wr_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rd_data(resp_rd_data),
    .resp_ack(resp_ack),
    .resp_timeout(resp_timeout),
    .ring_out_wr_data_bus(ring_out_wr_data_bus),
    .ring_out_ctrl(ring_out_ctrl),
    .ring_out_vld(ring_out_vld),
    .ring_out_rd_data_bus(ring_out_rd_data_bus),
    .ring_out_ack(ring_out_ack),
    .ring_in_wr_data_bus(ring_in_wr_data_bus),
    .ring_in_ctrl(ring_in_ctrl),
    .ring_in_vld(ring_in_vld),
    .ring_in_rd_data_bus(ring_in_rd_data_bus),
    .ring_in_ack(ring_in_ack),
    .stat_stale(stat_stale),
    .stat_timeout(stat_timeout)
  );

  // ---------------- ring node model and injection path ----------------
  // node_mode: 0 = ring open, 1 = ack and return node_rdata, 2 = pass unacked
  int          node_mode = 0;
  logic [31:0] node_rdata = 32'hCAFE_F00D;
  logic        node_vld = 1'b0;
  logic [6:0]  node_ctrl = '0;
  logic [59:0] node_bus = '0;
  logic [31:0] node_rd = '0;
  logic        node_ack = 1'b0;

  always @(posedge clk) begin
    node_vld  <= ring_out_vld && (node_mode != 0);
    node_ctrl <= ring_out_ctrl;
    node_bus  <= ring_out_wr_data_bus;
    node_ack  <= (node_mode == 1) ? 1'b1 : ring_out_ack;
    node_rd   <= (node_mode == 1) ? node_rdata : ring_out_rd_data_bus;
  end

  logic        inj_vld = 1'b0;
  logic [6:0]  inj_ctrl = '0;
  logic        inj_ack = 1'b0;
  logic [31:0] inj_rd = '0;

  assign ring_in_vld         = node_vld | inj_vld;
  assign ring_in_ctrl        = inj_vld ? inj_ctrl : node_ctrl;
  assign ring_in_wr_data_bus = inj_vld ? '0 : node_bus;
  assign ring_in_ack         = inj_vld ? inj_ack : node_ack;
  assign ring_in_rd_data_bus = inj_vld ? inj_rd : node_rd;

  // ---------------- bookkeeping ----------------
  int cyc = 0;
  int launch_cnt = 0;
  int accept_cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ring_out_vld) launch_cnt <= launch_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [63:0] sx(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, take the acceptance edge, check the launch.
  task automatic issue(input string tag, input logic rd, input logic [27:0] addr,
                       input logic [31:0] data);
    logic [6:0] ec;
    ec = {4'b0000, 2'b00, rd};
    req_valid   = 1'b1;
    req_rd_wr_L = rd;
    req_addr    = addr;
    req_wr_data = data;
    check({tag, "_ready_idle"}, req_ready, 1);
    tick();
    accept_cyc = cyc;
    req_valid  = 1'b0;
    check({tag, "_out_vld"}, ring_out_vld, 1);
    check({tag, "_out_bus"}, ring_out_wr_data_bus, {addr, data});
    check({tag, "_out_ctrl"}, ring_out_ctrl, ec);
    check({tag, "_out_rd_ack"}, {ring_out_rd_data_bus, ring_out_ack}, 33'd0);
    check({tag, "_ready_busy"}, req_ready, 0);
    $display("issue %s rd=%0b addr=%07h data=%08h", tag, rd, addr, data);
  endtask

  task automatic wait_resp(input string tag, output int lat);
    int n;
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    if (!resp_valid) check({tag, "_resp_bound"}, 0, 1);
    lat = cyc - accept_cyc;
    $display("resp  %s lat=%0d rd=%08h ack=%0b to=%0b", tag, lat, resp_rd_data, resp_ack, resp_timeout);
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_vld_clr"}, resp_valid, 0);
    check({tag, "_ready_back"}, req_ready, 1);
  endtask

  task automatic inject(input logic [1:0] src, input logic ack, input logic [31:0] rdata);
    inj_vld  = 1'b1;
    inj_ctrl = {4'b0000, src, 1'b1};
    inj_ack  = ack;
    inj_rd   = rdata;
    tick();
    inj_vld = 1'b0;
  endtask

  initial begin
    int lat;
    int lc;
    reset = 1'b1;
    req_valid = 1'b0;
    req_rd_wr_L = 1'b0;
    req_addr = '0;
    req_wr_data = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_resp", {resp_valid, resp_ack, resp_timeout, resp_rd_data}, 35'd0);
    check("rst_ring_out", {ring_out_vld, ring_out_ctrl, ring_out_wr_data_bus}, 68'd0);
    check("rst_stats", {stat_stale, stat_timeout}, 32'd0);
    tick();

    // Write with acking node: node offers read data that must be discarded
    node_mode = 1;
    lc = launch_cnt;
    issue("wr", 1'b0, 28'h000_0010, 32'h1234_5678);
    wait_resp("wr", lat);
    check("wr_lat", lat, 2);
    check("wr_ack", resp_ack, 1);
    check("wr_timeout", resp_timeout, 0);
    check("wr_rd_data", resp_rd_data, 32'h0);
    check("wr_launch_once", launch_cnt - lc, 1);
    finish_resp("wr");

    // Read with acking node
    issue("rd", 1'b1, 28'h000_0020, 32'h0);
    wait_resp("rd", lat);
    check("rd_lat", lat, 2);
    check("rd_data", resp_rd_data, 32'hCAFE_F00D);
    check("rd_ack", resp_ack, 1);
    check("rd_timeout", resp_timeout, 0);
    finish_resp("rd");

    // Read passed through unacked
    node_mode = 2;
    issue("noack", 1'b1, 28'h000_0024, 32'h0);
    wait_resp("noack", lat);
    check("noack_lat", lat, 2);
    check("noack_ack", resp_ack, 0);
    check("noack_timeout", resp_timeout, 0);
    check("noack_data", resp_rd_data, 32'h0);
    finish_resp("noack");

    // Ring open: timeout at ISSUE+9
    node_mode = 0;
    issue("to", 1'b1, 28'h000_0040, 32'h0);
    wait_resp("to", lat);
    check("to_lat", lat, 9);
    check("to_timeout", resp_timeout, 1);
    check("to_ack", resp_ack, 0);
    check("to_data", resp_rd_data, 32'hDEAD_BEEF);
    check("to_stat_timeout", stat_timeout, sx(1));
    finish_resp("to");
    inject(2'd0, 1'b1, 32'h1111_2222);   // late return in IDLE
    check("late_stale", stat_stale, sx(1));
    check("late_no_resp", resp_valid, 0);
    check("late_ready", req_ready, 1);

    // Wrong src during WAIT is ignored; real return two cycles later completes
    issue("src", 1'b1, 28'h000_0050, 32'h0);
    tick();
    inject(2'd3, 1'b1, 32'hBAD0_BAD0);
    tick();
    check("src_ignored", resp_valid, 0);
    check("src_stale", stat_stale, sx(2));
    inject(2'd0, 1'b1, 32'h55AA_33CC);
    wait_resp("src", lat);
    check("src_lat", lat, 4);
    check("src_data", resp_rd_data, 32'h55AA_33CC);
    check("src_ack", resp_ack, 1);
    finish_resp("src");

    // Match in the terminal-count cycle beats the timeout
    issue("race", 1'b1, 28'h000_0060, 32'h0);
    repeat (8) tick();
    check("race_pending", resp_valid, 0);
    inject(2'd0, 1'b1, 32'h0BAD_F00D);
    wait_resp("race", lat);
    check("race_lat", lat, 9);
    check("race_timeout", resp_timeout, 0);
    check("race_ack", resp_ack, 1);
    check("race_data", resp_rd_data, 32'h0BAD_F00D);
    check("race_stat_timeout", stat_timeout, sx(1));
    check("race_stale", stat_stale, sx(2));
    finish_resp("race");

    // Response back-pressure with a new request waiting
    node_mode = 1;
    issue("bp", 1'b1, 28'h000_0030, 32'h0);
    wait_resp("bp", lat);
    lc = launch_cnt;
    req_valid   = 1'b1;
    req_rd_wr_L = 1'b0;
    req_addr    = 28'h000_0034;
    req_wr_data = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_vld", resp_valid, 1);
      check("bp_hold_data", {resp_rd_data, resp_ack, resp_timeout}, {32'hCAFE_F00D, 1'b1, 1'b0});
      check("bp_ready_low", req_ready, 0);
      check("bp_out_vld", ring_out_vld, 0);
    end
    check("bp_no_launch", launch_cnt - lc, 0);
    req_valid = 1'b0;
    finish_resp("bp");

    // Reset during WAIT abandons the request
    node_mode = 0;
    issue("rw", 1'b1, 28'h000_0070, 32'h0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_ready", req_ready, 1);
    check("rw_resp", {resp_valid, resp_ack, resp_timeout, resp_rd_data}, 35'd0);
    check("rw_ring_out", {ring_out_vld, ring_out_ctrl, ring_out_wr_data_bus}, 68'd0);
    check("rw_stats", {stat_stale, stat_timeout}, 32'd0);
    inject(2'd0, 1'b1, 32'h7777_7777);
    check("rw_late_stale", stat_stale, sx(1));
    check("rw_late_no_resp", resp_valid, 0);
    tick();
    check("rw_idle_ready", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
